// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and constants for the wishbone line arbiter: bus widths, FSM state
// encoding and the modular index helper used by the picker and the pointer update.
package wb_rr_arbiter_pkg;

  localparam int WB_ADDR_W = 12;
  localparam int WB_DATA_W = 128;
  localparam int WB_SEL_W  = WB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } arb_state_t;

  function automatic int wrap_add(input int base, input int off, input int modulus);
    int sum;
    sum = base + off;
    return (sum >= modulus) ? (sum - modulus) : sum;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_priority_pick.sv
// Combinational requester pick: first set request at/after the start index, wrapping.
// Fixed-priority mode starts the scan at index 0.
module rr_priority_pick
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]       i_ptr,
  input  logic                   i_rr_mode,
  output logic [NUM_MASTERS-1:0] o_onehot,
  output logic [IDX_W-1:0]       o_idx
);

  int w_start;

  assign w_start = i_rr_mode ? int'(i_ptr) : 32'sd0;

  // scan requests in priority order from the start index, keep the first hit
  always_comb begin
    logic w_found;
    logic w_hit;
    int   w_pos;
    w_found  = 1'b0;
    w_hit    = 1'b0;
    w_pos    = 32'sd0;
    o_onehot = '0;
    o_idx    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_pos           = wrap_add(w_start, k, NUM_MASTERS);
      w_hit           = ~w_found & i_req[w_pos];
      o_onehot[w_pos] = o_onehot[w_pos] | w_hit;
      o_idx           = w_hit ? IDX_W'(w_pos) : o_idx;
      w_found         = w_found | w_hit;
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave wishbone line arbiter. The grant is registered and held for one
// whole transaction, followed by a single dead cycle with CYC low before the next owner.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int  NUM_MASTERS = 2,
  parameter int  ADDR_W      = WB_ADDR_W,
  parameter int  DATA_W      = WB_DATA_W,
  parameter int  SEL_W       = WB_SEL_W,
  parameter int  RR_MODE     = 1,
  localparam int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_cyc,
  input  logic [NUM_MASTERS-1:0]        m_stb,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_m,
  input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel,
  output logic [DATA_W-1:0]             m_dat_s,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [NUM_MASTERS-1:0]        m_rty,
  output logic                          s_cyc,
  output logic                          s_stb,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_adr,
  output logic [DATA_W-1:0]             s_dat_m,
  output logic [SEL_W-1:0]              s_sel,
  input  logic [DATA_W-1:0]             s_dat_s,
  input  logic                          s_ack,
  input  logic                          s_rty,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_idx
);

  arb_state_t             r_state;
  arb_state_t             w_next_state;
  logic [IDX_W-1:0]       r_grant_idx;
  logic [IDX_W-1:0]       w_next_grant;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]       w_next_ptr;
  logic [NUM_MASTERS-1:0] w_req;
  logic [NUM_MASTERS-1:0] w_pick_onehot;
  logic [IDX_W-1:0]       w_pick_idx;
  logic                   w_pick_any;
  logic                   w_busy;
  logic                   w_done;
  int                     w_g;

  assign w_req      = m_cyc & m_stb;
  assign w_pick_any = |w_pick_onehot;
  assign w_busy     = (r_state == BUSY);
  assign w_g        = int'(r_grant_idx);
  // completion (ACK/RTY) and abort (owner drops CYC) both end the tenure
  assign w_done     = s_ack | s_rty | ~m_cyc[r_grant_idx];

  rr_priority_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .i_req     (w_req),
    .i_ptr     (r_rr_ptr),
    .i_rr_mode (RR_MODE != 0),
    .o_onehot  (w_pick_onehot),
    .o_idx     (w_pick_idx)
  );

  // state, owner and round-robin pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_state     <= w_next_state;
      r_grant_idx <= w_next_grant;
      r_rr_ptr    <= w_next_ptr;
    end
  end

  // next-state logic; TURN is the dead cycle and may hand straight to the next owner
  always_comb begin
    w_next_state = r_state;
    w_next_grant = r_grant_idx;
    w_next_ptr   = r_rr_ptr;
    case (r_state)
      IDLE, TURN: begin
        if (w_pick_any) begin
          w_next_state = BUSY;
          w_next_grant = w_pick_idx;
        end else begin
          w_next_state = IDLE;
        end
      end
      BUSY: begin
        if (w_done) begin
          w_next_state = TURN;
          if (RR_MODE != 0) begin
            w_next_ptr = IDX_W'(wrap_add(w_g, 1, NUM_MASTERS));
          end else begin
            w_next_ptr = r_rr_ptr;
          end
        end else begin
          w_next_state = BUSY;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign grant_valid = w_busy;
  assign grant_idx   = r_grant_idx;
  assign m_dat_s     = s_dat_s;

  assign s_cyc   = w_busy & m_cyc[r_grant_idx];
  assign s_stb   = w_busy & m_stb[r_grant_idx];
  assign s_we    = w_busy & m_we[r_grant_idx];
  assign s_adr   = w_busy ? m_adr[w_g*ADDR_W +: ADDR_W]   : '0;
  assign s_dat_m = w_busy ? m_dat_m[w_g*DATA_W +: DATA_W] : '0;
  assign s_sel   = w_busy ? m_sel[w_g*SEL_W +: SEL_W]     : '0;

  // responses outside a tenure are dropped
  assign m_ack = w_busy ? ({{(NUM_MASTERS-1){1'b0}}, s_ack} << r_grant_idx) : '0;
  assign m_rty = w_busy ? ({{(NUM_MASTERS-1){1'b0}}, s_rty} << r_grant_idx) : '0;

endmodule
